vga_sync_monitor: RTL

VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

---
 rtl/vga_sync_monitor_if.sv | 29 ++
 rtl/vga_sync_monitor.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor_if.sv
// VGA pin bundle and measurement results exchanged with vga_sync_monitor.
// The master drives the sync/colour pins; the monitor (slave) returns measurements.
interface vga_sync_monitor_if;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;
  logic [11:0] h_period;
  logic [11:0] h_pulse;
  logic [9:0]  v_lines;
  logic [9:0]  v_pulse;
  logic [20:0] rgb_nz_cnt;
  logic [7:0]  frame_cnt;
  logic        frame_done;
  logic        locked;
  logic        h_err;
  logic        v_err;

  modport master (
    output hsync, vsync, rgb,
    input  h_period, h_pulse, v_lines, v_pulse, rgb_nz_cnt,
    input  frame_cnt, frame_done, locked, h_err, v_err
  );

  modport slave (
    input  hsync, vsync, rgb,
    output h_period, h_pulse, v_lines, v_pulse, rgb_nz_cnt,
    output frame_cnt, frame_done, locked, h_err, v_err
  );
endinterface

// File: rtl/vga_sync_monitor.sv
// Measures VGA sync timing against expected values, counts lit pixels per frame
// and tracks lock through a SEEK/MEASURE/LOCKED state machine.
module vga_sync_monitor #(
  parameter int unsigned H_PERIOD = 3200,
  parameter int unsigned H_PULSE  = 384,
  parameter int unsigned V_LINES  = 525,
  parameter int unsigned V_PULSE  = 2,
  parameter int unsigned TIMEOUT  = 4095
) (
  input  logic           clk,
  input  logic           rst,
  vga_sync_monitor_if.slave vga
);
  typedef enum logic [1:0] {SEEK, MEASURE, LOCKED} state_e;

  localparam logic [11:0] H_PERIOD_C = 12'(H_PERIOD);
  localparam logic [11:0] H_PULSE_C  = 12'(H_PULSE);
  localparam logic [9:0]  V_LINES_C  = 10'(V_LINES);
  localparam logic [9:0]  V_PULSE_C  = 10'(V_PULSE);
  localparam logic [11:0] TIMEOUT_C  = 12'(TIMEOUT);

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  function automatic logic [20:0] sat_inc21(input logic [20:0] v);
    return (v == 21'h1FFFFF) ? v : v + 21'd1;
  endfunction

  logic        hs_p0_q, hs_p1_q, hs_p2_q;
  logic        vs_p0_q, vs_p1_q, vs_p2_q;
  logic [11:0] rgb_p0_q, rgb_p1_q;
  logic [11:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [9:0]  vpcnt_q, vpcnt_d;
  logic [20:0] acc_q, acc_d;
  state_e      state_q;
  logic [11:0] h_period_q, h_pulse_q;
  logic [9:0]  v_lines_q, v_pulse_q;
  logic [20:0] rgb_nz_cnt_q;
  logic [7:0]  frame_cnt_q;
  logic        frame_done_q, locked_q, h_err_q, v_err_q;

  logic        hfall, hrise, vfall, vrise, rgb_nz, timeout, active;
  logic [11:0] h_meas, h_period_new;
  logic [9:0]  v_lines_new;
  logic        h_bad, v_bad;

  // p0/p1: two-flop synchronizers; p2: previous synchronized sync level
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_p0_q  <= 1'b0;
      hs_p1_q  <= 1'b0;
      hs_p2_q  <= 1'b0;
      vs_p0_q  <= 1'b0;
      vs_p1_q  <= 1'b0;
      vs_p2_q  <= 1'b0;
      rgb_p0_q <= 12'd0;
      rgb_p1_q <= 12'd0;
    end else begin
      hs_p0_q  <= vga.hsync;
      hs_p1_q  <= hs_p0_q;
      hs_p2_q  <= hs_p1_q;
      vs_p0_q  <= vga.vsync;
      vs_p1_q  <= vs_p0_q;
      vs_p2_q  <= vs_p1_q;
      rgb_p0_q <= vga.rgb;
      rgb_p1_q <= rgb_p0_q;
    end
  end

  assign hfall        = hs_p2_q & ~hs_p1_q;
  assign hrise        = ~hs_p2_q & hs_p1_q;
  assign vfall        = vs_p2_q & ~vs_p1_q;
  assign vrise        = ~vs_p2_q & vs_p1_q;
  assign rgb_nz       = |rgb_p1_q;
  assign timeout      = (hcnt_q == TIMEOUT_C);
  assign active       = (state_q != SEEK);
  assign h_meas       = sat_inc12(hcnt_q);
  assign h_period_new = hfall ? h_meas : h_period_q;
  // An hfall coinciding with vfall closes the ending frame's last line
  assign v_lines_new  = vcnt_q + {9'd0, hfall};
  assign h_bad        = (h_period_new != H_PERIOD_C) || (h_pulse_q != H_PULSE_C);
  assign v_bad        = (v_lines_new != V_LINES_C) || (v_pulse_q != V_PULSE_C);

  always_comb begin
    hcnt_d  = hfall ? 12'd0 : sat_inc12(hcnt_q);
    vcnt_d  = vcnt_q;
    vpcnt_d = vpcnt_q;
    if (vfall) begin
      vcnt_d  = 10'd0;
      vpcnt_d = {9'd0, hfall};
    end else if (hfall) begin
      vcnt_d = vcnt_q + 10'd1;
      if (!vs_p1_q) vpcnt_d = vpcnt_q + 10'd1;
    end
    acc_d = vfall ? {20'd0, rgb_nz} : (rgb_nz ? sat_inc21(acc_q) : acc_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q  <= 12'd0;
      vcnt_q  <= 10'd0;
      vpcnt_q <= 10'd0;
      acc_q   <= 21'd0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      vpcnt_q <= vpcnt_d;
      acc_q   <= acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SEEK;
      h_period_q   <= 12'd0;
      h_pulse_q    <= 12'd0;
      v_lines_q    <= 10'd0;
      v_pulse_q    <= 10'd0;
      rgb_nz_cnt_q <= 21'd0;
      frame_cnt_q  <= 8'd0;
      frame_done_q <= 1'b0;
      locked_q     <= 1'b0;
      h_err_q      <= 1'b0;
      v_err_q      <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (hfall) h_period_q <= h_meas;
      if (hrise) h_pulse_q  <= h_meas;
      if (active) begin
        if (vrise) v_pulse_q <= vpcnt_q;
        if (vfall) begin
          v_lines_q    <= v_lines_new;
          rgb_nz_cnt_q <= acc_q;
          frame_done_q <= 1'b1;
          frame_cnt_q  <= frame_cnt_q + 8'd1;
          if (v_bad) v_err_q <= 1'b1;
        end
        if (hfall && h_bad) h_err_q <= 1'b1;
      end
      case (state_q)
        SEEK:    if (vfall) state_q <= MEASURE;
        MEASURE: if (vfall && !v_bad && !h_bad) begin
          state_q  <= LOCKED;
          locked_q <= 1'b1;
        end
        LOCKED:  if ((hfall && h_bad) || (vfall && v_bad)) begin
          state_q  <= MEASURE;
          locked_q <= 1'b0;
        end
        default: begin
          state_q  <= SEEK;
          locked_q <= 1'b0;
        end
      endcase
      if (timeout) begin
        state_q  <= SEEK;
        locked_q <= 1'b0;
        h_err_q  <= 1'b1;
      end
    end
  end

  assign vga.h_period   = h_period_q;
  assign vga.h_pulse    = h_pulse_q;
  assign vga.v_lines    = v_lines_q;
  assign vga.v_pulse    = v_pulse_q;
  assign vga.rgb_nz_cnt = rgb_nz_cnt_q;
  assign vga.frame_cnt  = frame_cnt_q;
  assign vga.frame_done = frame_done_q;
  assign vga.locked     = locked_q;
  assign vga.h_err      = h_err_q;
  assign vga.v_err      = v_err_q;
endmodule
